vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the DE0 VGA driver. It samples the sync pins and 12-bit color bus at the pixel strobe and recovers the X/Y position of every visible pixel. It checks the 640x480@60 line and frame timing and reports lock and error status. It sits on the loop-back/self-check path beside the Pong video top, so the bench and on-board checkers can compare drawn pixels (paddles, ball) against expected coordinates.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, sync polarity; 1 means the asserted level of the sync pins is 0
- LOCK_FRAMES, 2, consecutive error-free frames required to lock

Derived: H_TOTAL = 800, V_TOTAL = 525.

Ports (one clock; reset is synchronous and active-high):
- clk_50  in  1  50 MHz system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel strobe, one clk_50 cycle in two
- vga_hs  in  1  horizontal sync pin
- vga_vs  in  1  vertical sync pin
- vga_r / vga_g / vga_b  in  4 each  color bus
- x_pix  out  10  recovered column, 0..639
- y_pix  out  10  recovered row, 0..479
- pix_valid  out  1  x_pix, y_pix and pix_color are valid this cycle
- pix_color  out  12  {B,G,R}: blue in [11:8], red in [3:0]
- locked  out  1  state is LOCKED
- frame_done  out  1  one-cycle pulse on the last visible pixel of a frame
- h_err  out  1  one-cycle pulse on a horizontal timing violation
- v_err  out  1  one-cycle pulse on a vertical timing violation
- err_cnt  out  8  saturating count of error cycles

## Operation
- All inputs are sampled only on pix_en cycles.
- "Asserted" means the sync pin is at its active level (low when SYNC_ACTIVE_LOW=1).
- Edge detection works on consecutive pix_en samples:
  - HS fall = HS becomes asserted; HS rise = HS becomes deasserted.
  - VS fall = VS becomes asserted.
- Horizontal phase counter hph (10 bits):
  - Set to 0 on an HS fall sample; otherwise increments on each pix_en.
  - Saturates at 1023. Reaching 1023 is a timeout: pulse h_err once and go to SEARCH.
- VS handling: a VS fall sets vs_pend. At the next HS fall, vph is set to 0 and vs_pend is cleared. On any other HS fall, vph increments (saturating at 1023).
- Visible window:
  - Columns: hph in [H_SYNC+H_BP, H_SYNC+H_BP+H_VIS-1] = 144..783, with x = hph-144.
  - Rows: vph in [V_SYNC+V_BP, +V_VIS-1] = 35..514, with y = vph-35.
- Checks, active outside SEARCH and only after one HS fall has been seen:
  - h_err if an HS fall arrives with previous hph != H_TOTAL-1 (799).
  - h_err if an HS rise arrives with hph != H_SYNC (96).
  - v_err if the vs_pend application arrives with previous vph != V_TOTAL-1 (524).
- State machine:
  - SEARCH -> ACQUIRE on the first vs_pend application. Clear the good-frame count.
  - ACQUIRE: a frame is good if no h_err/v_err occurred since the previous application. Increment the good count on each good application; any error clears it. Go to LOCKED when the count reaches LOCK_FRAMES.
  - LOCKED: any h_err or v_err -> ACQUIRE with the count cleared. A timeout -> SEARCH.
- Outputs:
  - pix_valid = LOCKED and inside the visible window.
  - When pix_valid is 0, x_pix, y_pix and pix_color are 0.
  - frame_done pulses with pix_valid at x=639, y=479.
- err_cnt adds 1 per cycle in which h_err or v_err is set. Simultaneous h_err and v_err count as 1. It saturates at 255 and is cleared only by rst.

## Timing
- All outputs are registered.
- Results for the sample taken on a pix_en cycle appear on the next clk_50 cycle and are held for one cycle.
- Outputs are 0 in cycles that do not follow a pix_en sample.
- Reset values: every output 0; state SEARCH; hph = vph = 0; vs_pend = 0; edge-history registers hold the deasserted level.
- rst asserted mid-frame takes effect on the next clk_50 edge. Re-lock then requires a fresh VS fall plus LOCK_FRAMES good frames.
- Simultaneous HS fall and VS fall in the same sample: vs_pend is set and applied on that same HS fall.
- Minimum lock latency from rst release with clean input: 1 + LOCK_FRAMES frame boundaries.

## Structure
- Shared package vga_timing_pkg:
  - The 640x480 timing constants and derived totals, shared with the DE0 VGA driver.
  - The {SEARCH, ACQUIRE, LOCKED} state type.
- One sub-module, sync_edge_detect, instantiated for HS and VS:
  - Inputs: clk_50, rst, pix_en, the sync pin, and the polarity parameter.
  - Outputs: fall and rise pulses and the registered level.

## Test plan
- Clean 640x480 stream, vertical color bars, from rst release:
  - locked rises after the third VS application.
  - First valid pixel x=0, y=0, one cycle after the sample with hph=144.
  - frame_done at x=639, y=479; err_cnt = 0.
- Stream of a 48x48 box drawn at (100,200) while locked: pix_color = 12'h00F exactly for x 101..147 and y 201..247, and the background value elsewhere.
- One line of 799 pixels while locked: single h_err pulse, locked drops, err_cnt = 1, re-lock after 2 good frames.
- HS pulse of 95 pixels: h_err on the rise. Frame with 524 lines: v_err at the VS application.
- HS held deasserted for 1100 pixels while locked: one h_err at the timeout, state SEARCH, pix_valid stays 0 until re-acquired.
- rst pulsed mid-frame at y=240: all outputs 0 on the next cycle, locked re-asserts only after 1 + LOCK_FRAMES frame boundaries.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing shared with the DE0 VGA driver,
// plus the lock state type of the receive-side sync decoder.
package vga_timing_pkg;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP
                               + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP
                               + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } sync_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: polarity-normalised sync level history with
// assert (fall) / deassert (rise) pulses on pixel-strobe samples.
module sync_edge_detect #(
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic clk_50,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_pin,
    output logic fall,
    output logic rise,
    output logic level
);

    localparam logic POL_LOW = (SYNC_ACTIVE_LOW != 0);

    logic asserted;

    assign asserted = POL_LOW ? ~sync_pin : sync_pin;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            level <= 1'b0;
        end else if (pix_en) begin
            level <= asserted;
        end
    end

    assign fall = pix_en & asserted & ~level;
    assign rise = pix_en & ~asserted & level;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel X/Y from sampled VGA sync/colour pins,
// checks line/frame timing and tracks lock.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VIS           = VGA_H_VIS,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_VIS           = VGA_V_VIS,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic [9:0]  x_pix,
    output logic [9:0]  y_pix,
    output logic        pix_valid,
    output logic [11:0] pix_color,
    output logic        locked,
    output logic        frame_done,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_PW   = 10'(H_SYNC);
    localparam logic [9:0] X_LO   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] X_HI   = 10'(H_SYNC + H_BP + H_VIS - 1);
    localparam logic [9:0] Y_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] Y_HI   = 10'(V_SYNC + V_BP + V_VIS - 1);
    localparam logic [9:0] X_END  = 10'(H_VIS - 1);
    localparam logic [9:0] Y_END  = 10'(V_VIS - 1);
    localparam logic [9:0] PH_MAX = 10'h3FF;
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    sync_state_t state, st_n;

    logic [9:0] hph, hph_n;
    logic [9:0] vph, vph_n;
    logic       vs_pend, pend_n;
    logic [7:0] good_cnt, good_n;
    logic       frame_bad, bad_n;
    logic [7:0] err_acc, err_n;

    logic hs_fall, hs_rise, hs_lvl;
    logic vs_fall, vs_rise, vs_lvl;
    logic unused_sync;

    logic chk, apply, tmo, h_bad, v_bad, err_c;
    logic in_win, vis;
    logic [9:0] x_c, y_c;

    sync_edge_detect #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_hs (
        .clk_50   (clk_50),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync_pin (vga_hs),
        .fall     (hs_fall),
        .rise     (hs_rise),
        .level    (hs_lvl)
    );

    sync_edge_detect #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_vs (
        .clk_50   (clk_50),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync_pin (vga_vs),
        .fall     (vs_fall),
        .rise     (vs_rise),
        .level    (vs_lvl)
    );

    assign unused_sync = hs_lvl ^ vs_lvl ^ vs_rise;
    assign chk         = (state != SEARCH);

    // A VS fall is applied at the HS fall of the same or a later sample.
    always_comb begin
        hph_n  = hph;
        vph_n  = vph;
        pend_n = vs_pend;
        apply  = 1'b0;
        tmo    = 1'b0;
        h_bad  = 1'b0;
        v_bad  = 1'b0;
        if (hs_fall) begin
            hph_n = '0;
            h_bad = chk && (hph != H_LAST);
            if (vs_pend || vs_fall) begin
                apply  = 1'b1;
                pend_n = 1'b0;
                vph_n  = '0;
                v_bad  = chk && (vph != V_LAST);
            end else if (vph != PH_MAX) begin
                vph_n = vph + 10'd1;
            end
        end else if (pix_en) begin
            pend_n = vs_pend | vs_fall;
            if (hph != PH_MAX) begin
                hph_n = hph + 10'd1;
            end
            tmo = chk && (hph == PH_MAX - 10'd1);
            if (hs_rise && chk && (hph_n != H_PW)) begin
                h_bad = 1'b1;
            end
        end
    end

    assign err_c = h_bad | tmo | v_bad;

    always_comb begin
        st_n   = state;
        good_n = good_cnt;
        bad_n  = apply ? 1'b0 : (frame_bad | err_c);
        unique case (state)
            SEARCH: begin
                if (apply) begin
                    st_n   = ACQUIRE;
                    good_n = '0;
                end
            end
            ACQUIRE: begin
                if (tmo) begin
                    st_n = SEARCH;
                end else if (apply) begin
                    if (frame_bad || err_c) begin
                        good_n = '0;
                    end else begin
                        good_n = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_N) begin
                            st_n = LOCKED;
                        end
                    end
                end else if (err_c) begin
                    good_n = '0;
                end
            end
            LOCKED: begin
                if (tmo) begin
                    st_n = SEARCH;
                end else if (err_c) begin
                    st_n   = ACQUIRE;
                    good_n = '0;
                end
            end
            default: begin
                st_n = SEARCH;
            end
        endcase
    end

    assign err_n  = (err_c && err_acc != 8'hFF) ? err_acc + 8'd1 : err_acc;
    assign in_win = (hph_n >= X_LO) && (hph_n <= X_HI)
                 && (vph_n >= Y_LO) && (vph_n <= Y_HI);
    assign vis    = pix_en && (st_n == LOCKED) && in_win;
    assign x_c    = hph_n - X_LO;
    assign y_c    = vph_n - Y_LO;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state     <= SEARCH;
            hph       <= '0;
            vph       <= '0;
            vs_pend   <= 1'b0;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
            err_acc   <= '0;
        end else begin
            state     <= st_n;
            hph       <= hph_n;
            vph       <= vph_n;
            vs_pend   <= pend_n;
            good_cnt  <= good_n;
            frame_bad <= bad_n;
            err_acc   <= err_n;
        end
    end

    // Results exist only in the cycle right after a pixel sample.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            x_pix      <= '0;
            y_pix      <= '0;
            pix_valid  <= 1'b0;
            pix_color  <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            x_pix      <= vis ? x_c : '0;
            y_pix      <= vis ? y_c : '0;
            pix_valid  <= vis;
            pix_color  <= vis ? {vga_b, vga_g, vga_r} : '0;
            locked     <= pix_en && (st_n == LOCKED);
            frame_done <= vis && (x_c == X_END) && (y_c == Y_END);
            h_err      <= h_bad | tmo;
            v_err      <= v_bad;
            err_cnt    <= pix_en ? err_n : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: small-raster stream with randomized colours and
// pins, checked against a pixel-level reference model.
module tb_vga_sync_decoder;

    localparam int HV  = 16;
    localparam int HFP = 2;
    localparam int HSW = 4;
    localparam int HBP = 3;
    localparam int VV  = 8;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int LF  = 2;
    localparam int HT  = HV + HFP + HSW + HBP;
    localparam int VT  = VV + VFP + VSW + VBP;
    localparam int X0  = HSW + HBP;
    localparam int Y0  = VSW + VBP;
    localparam int BW  = 5;
    localparam int BH  = 3;

    localparam int ST_SEARCH = 0;
    localparam int ST_ACQ    = 1;
    localparam int ST_LOCK   = 2;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [9:0]  x_pix, y_pix;
    logic        pix_valid, locked, frame_done, h_err, v_err;
    logic [11:0] pix_color;
    logic [7:0]  err_cnt;
    logic [44:0] outs;

    int n_checks = 0;
    int n_fail = 0;

    bit m_hs, m_vs, m_pend, m_bad;
    int m_h, m_v, m_st, m_good, m_err;

    int g_row, g_col, frame_no;
    int cnt_herr, cnt_verr, cnt_valid, cnt_fd, cnt_red;
    bit last_locked, seen_lock, seen_valid, box_on;
    int lock_frame, last_err, bx, by;

    vga_sync_decoder #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF)
    ) dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .pix_en     (pix_en),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .x_pix      (x_pix),
        .y_pix      (y_pix),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .locked     (locked),
        .frame_done (frame_done),
        .h_err      (h_err),
        .v_err      (v_err),
        .err_cnt    (err_cnt)
    );

    always #10 clk_50 = ~clk_50;

    assign outs = {x_pix, y_pix, pix_valid, pix_color, locked,
                   frame_done, h_err, v_err, err_cnt};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hs = 0; m_vs = 0; m_pend = 0; m_bad = 0;
        m_h = 0; m_v = 0; m_st = ST_SEARCH; m_good = 0; m_err = 0;
    endtask

    // Reference: position = samples since the last line start, line =
    // lines since the frame start; lock after LF clean frames.
    task automatic model_step(input bit hs_a, input bit vs_a,
                              input logic [11:0] c,
                              output logic [44:0] e);
        bit fall, rise, vfall, chk, apply, he, ve, tmo, err, vis, fd;
        int ex, ey;
        fall = hs_a && !m_hs;
        rise = !hs_a && m_hs;
        vfall = vs_a && !m_vs;
        m_hs = hs_a;
        m_vs = vs_a;
        chk = (m_st != ST_SEARCH);
        apply = 0; he = 0; ve = 0; tmo = 0;
        if (vfall) m_pend = 1;
        if (fall) begin
            if (chk && m_h != HT - 1) he = 1;
            m_h = 0;
            if (m_pend) begin
                apply = 1;
                m_pend = 0;
                if (chk && m_v != VT - 1) ve = 1;
                m_v = 0;
            end else if (m_v < 1023) begin
                m_v++;
            end
        end else if (m_h < 1023) begin
            m_h++;
            if (m_h == 1023 && chk) begin
                tmo = 1;
                he = 1;
            end
        end
        if (rise && chk && m_h != HSW) he = 1;
        err = he || ve;
        if (tmo) begin
            m_st = ST_SEARCH;
        end else if (m_st == ST_SEARCH) begin
            if (apply) begin
                m_st = ST_ACQ;
                m_good = 0;
            end
        end else if (m_st == ST_ACQ) begin
            if (apply) begin
                if (m_bad || err) m_good = 0;
                else m_good++;
                if (m_good == LF) m_st = ST_LOCK;
            end else if (err) begin
                m_good = 0;
            end
        end else if (err) begin
            m_st = ST_ACQ;
            m_good = 0;
        end
        m_bad = apply ? 1'b0 : (m_bad || err);
        if (err && m_err < 255) m_err++;
        vis = (m_st == ST_LOCK) && m_h >= X0 && m_h < X0 + HV
              && m_v >= Y0 && m_v < Y0 + VV;
        ex = vis ? m_h - X0 : 0;
        ey = vis ? m_v - Y0 : 0;
        fd = vis && ex == HV - 1 && ey == VV - 1;
        e = {10'(ex), 10'(ey), vis, vis ? c : 12'h000,
             m_st == ST_LOCK, fd, he, ve, 8'(m_err)};
    endtask

    task automatic observe();
        if (h_err) cnt_herr++;
        if (v_err) cnt_verr++;
        if (pix_valid) cnt_valid++;
        if (frame_done) cnt_fd++;
        if (pix_valid && pix_color == 12'h00F) cnt_red++;
        if (locked && !last_locked && !seen_lock) begin
            seen_lock = 1;
            lock_frame = frame_no;
        end
        if (pix_valid && !seen_valid) begin
            seen_valid = 1;
            check("first_xy", {x_pix, y_pix}, 0);
            check("first_col", g_col, X0);
            check("first_row", g_row, Y0);
        end
        last_locked = locked;
        last_err = err_cnt;
    endtask

    task automatic send_pixel(input bit hs_a, input bit vs_a,
                              input logic [11:0] c);
        logic [44:0] e;
        pix_en = 1;
        vga_hs = ~hs_a;
        vga_vs = ~vs_a;
        {vga_b, vga_g, vga_r} = c;
        model_step(hs_a, vs_a, c, e);
        @(negedge clk_50);
        check("sample", outs, e);
        observe();
        pix_en = 0;
        {vga_hs, vga_vs, vga_b, vga_g, vga_r} = 14'($urandom);
        @(negedge clk_50);
        check("idle", outs, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        pix_en = 1;
        {vga_hs, vga_vs, vga_b, vga_g, vga_r} = 14'($urandom);
        @(negedge clk_50);
        check("rst_zero", outs, 0);
        rst = 0;
        pix_en = 0;
        model_reset();
        last_locked = 0;
        @(negedge clk_50);
        check("rst_idle", outs, 0);
    endtask

    task automatic send_line(input int row, input int len, input int hsw,
                             input bit vs_a);
        logic [11:0] c;
        logic [3:0] bar;
        int vx, vy;
        g_row = row;
        for (int p = 0; p < len; p++) begin
            g_col = p;
            c = 12'($urandom);
            if (p >= X0 && p < X0 + HV && row >= Y0 && row < Y0 + VV) begin
                vx = p - X0;
                vy = row - Y0;
                bar = 4'(vx >> 1);
                c = {bar, ~bar, 4'h0};
                if (box_on && vx > bx && vx < bx + BW
                    && vy > by && vy < by + BH) c = 12'h00F;
            end
            send_pixel(p < hsw, vs_a, c);
        end
    endtask

    task automatic send_frame(input int nl, input int short_row,
                              input int hs_row, input int rst_row);
        frame_no++;
        for (int r = 0; r < nl; r++) begin
            if (r == rst_row) do_reset();
            send_line(r, (r == short_row) ? HT - 1 : HT,
                      (r == hs_row) ? HSW - 1 : HSW, r < VSW);
        end
    endtask

    initial begin
        model_reset();
        frame_no = 0; seen_lock = 0; seen_valid = 0; box_on = 0;
        last_locked = 0; lock_frame = 0; last_err = 0;
        cnt_herr = 0; cnt_verr = 0; cnt_valid = 0; cnt_fd = 0; cnt_red = 0;
        bx = 0; by = 0;

        repeat (3) @(negedge clk_50);
        check("reset", outs, 0);
        rst = 0;
        @(negedge clk_50);
        check("post_reset", outs, 0);

        repeat (4) send_frame(VT, -1, -1, -1);
        check("lock_at_start", lock_frame, 3);
        check("fd_count", cnt_fd, 2);
        check("err_clean", last_err, 0);

        box_on = 1;
        bx = $urandom_range(0, HV - BW);
        by = $urandom_range(0, VV - BH);
        cnt_red = 0;
        send_frame(VT, -1, -1, -1);
        box_on = 0;
        check("box_count", cnt_red, (BW - 1) * (BH - 1));
        check("box_locked", last_locked, 1);

        frame_no = 0; seen_lock = 0; cnt_herr = 0;
        send_frame(VT, 6, -1, -1);
        check("herr_short", cnt_herr, 1);
        check("lock_drop", last_locked, 0);
        check("err_short", last_err, 1);
        repeat (4) send_frame(VT, -1, -1, -1);
        check("relock_short", lock_frame, 4);

        cnt_herr = 0;
        send_frame(VT, -1, 5, -1);
        check("herr_hs_narrow", cnt_herr, 1);
        cnt_verr = 0;
        send_frame(VT - 1, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        check("verr_short", cnt_verr, 1);
        repeat (3) send_frame(VT, -1, -1, -1);
        check("relock_v", last_locked, 1);
        check("err_three", last_err, 3);

        send_frame(6, -1, -1, -1);
        cnt_herr = 0; cnt_valid = 0;
        for (int i = 0; i < 1100; i++) send_pixel(0, 0, 12'($urandom));
        check("herr_tmo", cnt_herr, 1);
        check("tmo_unlock", last_locked, 0);
        frame_no = 0; seen_lock = 0;
        repeat (2) send_frame(VT, -1, -1, -1);
        check("valid_search", cnt_valid, 0);
        send_frame(VT, -1, -1, -1);
        check("relock_tmo", lock_frame, 3);

        frame_no = 0; seen_lock = 0;
        send_frame(VT, -1, -1, Y0 + VV / 2);
        repeat (3) send_frame(VT, -1, -1, -1);
        check("relock_rst", lock_frame, 4);
        check("err_after_rst", last_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
